// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: accumulates NUM_TERMS signed terms into one matrix element with sticky overflow
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
module dot_product_accumulator #(
    parameter int BIT_WIDTH = `BIT_WIDTH,
    parameter int NUM_TERMS = 4,
    localparam int CW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] in_data,
    input  logic                        in_sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] out_data,
    output logic                        out_overflow,
    output logic [CW-1:0]               term_count
);
    typedef enum logic {ACCUM, DONE} state_t;
    state_t state, state_next;
    logic signed [BIT_WIDTH-1:0] acc, sum;
    logic ovf, term_ovf, accept, last;
    assign in_ready  = state == ACCUM;
    assign out_valid = state == DONE;
    assign accept    = in_valid & in_ready & ~clr;
    assign last      = term_count == CW'(NUM_TERMS - 1);
    assign sum       = in_sub ? acc - in_data : acc + in_data;
    // Overflow when the operand signs make a sign change of the result impossible without wrapping
    assign term_ovf  = (in_sub ? acc[BIT_WIDTH-1] != in_data[BIT_WIDTH-1] : acc[BIT_WIDTH-1] == in_data[BIT_WIDTH-1])
                       && sum[BIT_WIDTH-1] != acc[BIT_WIDTH-1];
    // Next state: abort wins, last accepted term finishes, handshake releases the result
    always_comb begin
        state_next = state;
        if (clr)
            state_next = ACCUM;
        else if (state == ACCUM)
            state_next = (accept && last) ? DONE : ACCUM;
        else
            state_next = out_ready ? ACCUM : DONE;
    end
    // Running sum, term counter, sticky overflow and captured result
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            ovf          <= 1'b0;
            term_count   <= '0;
            out_data     <= '0;
            out_overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (clr || (state == DONE && out_ready)) begin
                acc        <= '0;
                ovf        <= 1'b0;
                term_count <= '0;
            end else if (accept) begin
                acc        <= sum;
                ovf        <= ovf | term_ovf;
                term_count <= last ? '0 : term_count + CW'(1);
                if (last) begin
                    out_data     <= sum;
                    out_overflow <= ovf | term_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb_dot_product_accumulator: directed self-checking bench for dot_product_accumulator (8-bit, 4 terms)
module tb_dot_product_accumulator;
    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
    logic signed [7:0] in_data = '0;
    logic in_ready, out_valid, out_overflow;
    logic signed [7:0] out_data;
    logic [1:0] term_count;
    int total = 0, bad = 0;

    dot_product_accumulator #(.BIT_WIDTH(8), .NUM_TERMS(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_overflow(out_overflow), .term_count(term_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        tick();
        in_valid = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic feed4(input logic signed [7:0] a, b, c, d);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_data !== 8'sd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL reset_out_overflow got=%b want=0", out_overflow); end
        total++; if (term_count !== 2'd0) begin bad++; $display("FAIL reset_term_count got=%0d want=0", term_count); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(8'sd10, 1'b0);
        send(8'sd20, 1'b0);
        total++; if (term_count !== 2'd2) begin bad++; $display("FAIL basic_term_count got=%0d want=2", term_count); end
        send(-8'sd5, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
        send(8'sd7, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_done got=%b want=0", in_ready); end
        total++; if (out_data !== 8'sd32) begin bad++; $display("FAIL basic_out_data got=%0d want=32", out_data); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%b want=0", out_overflow); end
        tick();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_release got=%b/%b want=1/0", in_ready, out_valid); end
    endtask

    task automatic test_overflow();
        feed4(8'sd100, 8'sd50, -8'sd100, 8'sd0);
        total++; if (out_data !== 8'sd50) begin bad++; $display("FAIL ovf_out_data got=%0d want=50", out_data); end
        total++; if (out_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", out_overflow); end
        tick();
        send(-8'sd128, 1'b1);
        send(8'sd0, 1'b0);
        send(8'sd0, 1'b0);
        send(8'sd0, 1'b0);
        total++; if (out_data !== -8'sd128) begin bad++; $display("FAIL sub_min_out_data got=%0d want=-128", out_data); end
        total++; if (out_overflow !== 1'b1) begin bad++; $display("FAIL sub_min_flag got=%b want=1", out_overflow); end
        tick();
        feed4(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        total++; if (out_data !== 8'sd4) begin bad++; $display("FAIL sticky_clear_data got=%0d want=4", out_data); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL sticky_clear_flag got=%b want=0", out_overflow); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        feed4(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        in_valid = 1'b1;
        in_data  = 8'sd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'sd4) begin
                bad++; $display("FAIL bp_hold cycle=%0d got ready=%b valid=%b data=%0d want 0/1/4", i, in_ready, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1 || term_count !== 2'd0) begin bad++; $display("FAIL bp_restart got ready=%b count=%0d want 1/0", in_ready, term_count); end
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 8'sd36) begin bad++; $display("FAIL bp_next got valid=%b data=%0d want 1/36", out_valid, out_data); end
        tick();
    endtask

    task automatic test_abort();
        send(8'sd3, 1'b0);
        send(8'sd3, 1'b0);
        clr = 1'b1;
        send(8'sd3, 1'b0);
        clr = 1'b0;
        total++; if (term_count !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL clr_state got count=%0d valid=%b want 0/0", term_count, out_valid); end
        feed4(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        total++; if (out_valid !== 1'b1 || out_data !== 8'sd4) begin bad++; $display("FAIL clr_result got valid=%b data=%0d want 1/4", out_valid, out_data); end
        tick();
        send(8'sd3, 1'b0);
        send(8'sd3, 1'b0);
        rst = 1'b1;
        send(8'sd3, 1'b0);
        rst = 1'b0;
        total++; if (term_count !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'sd0) begin
            bad++; $display("FAIL rst_state got count=%0d valid=%b data=%0d want 0/0/0", term_count, out_valid, out_data);
        end
        feed4(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        total++; if (out_valid !== 1'b1 || out_data !== 8'sd4) begin bad++; $display("FAIL rst_result got valid=%b data=%0d want 1/4", out_valid, out_data); end
        tick();
        out_ready = 1'b0;
        feed4(8'sd5, 8'sd5, 8'sd5, 8'sd5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'sd20) begin
            bad++; $display("FAIL clr_done got valid=%b ready=%b data=%0d want 0/1/20", out_valid, in_ready, out_data);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_gapped();
        logic signed [7:0] terms [4];
        logic subs [4];
        terms = '{8'sd2, -8'sd3, 8'sd4, -8'sd1};
        subs  = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(terms[i], subs[i]);
            if (i == 3) begin
                total++; if (out_valid !== 1'b1 || out_data !== 8'sd8) begin bad++; $display("FAIL gap_result got valid=%b data=%0d want 1/8", out_valid, out_data); end
            end else begin
                tick();
                tick();
                total++; if (out_valid !== 1'b0 || term_count !== 2'(i + 1)) begin
                    bad++; $display("FAIL gap_hold term=%0d got valid=%b count=%0d want 0/%0d", i, out_valid, term_count, i + 1);
                end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_abort();
        test_gapped();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
